// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - pipelined ALU with valid/ready input and valid/yumi output handshake
// Build option: ALU_PIPE_SAT_EN makes add/sub saturate instead of wrapping.
module alu_pipe #(
   parameter int width_p   = 8,
   parameter int latency_p = 2
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic [2:0]         sel_i,
   input  logic [width_p-1:0] a_i,
   input  logic [width_p-1:0] b_i,
   output logic               v_o,
   input  logic               yumi_i,
   output logic [width_p-1:0] res_o,
   output logic               carry_o,
   output logic               zero_o
);

   localparam int sh_w_lp = $clog2(width_p);

   logic [width_p:0]     add_w;
   logic [width_p:0]     sub_w;
   logic [sh_w_lp-1:0]   shamt;
   logic [width_p-1:0]   alu_res;
   logic                 alu_carry;
   logic                 alu_zero;

   logic [latency_p-1:0] valid_q;
   logic [latency_p-1:0] carry_q;
   logic [latency_p-1:0] zero_q;
   logic [width_p-1:0]   res_q [latency_p];
   logic [latency_p-1:0] stage_rdy;
   logic                 all_full;

   always_comb begin
      add_w     = {1'b0, a_i} + {1'b0, b_i};
      sub_w     = {1'b0, a_i} - {1'b0, b_i};
      shamt     = b_i[sh_w_lp-1:0];
      alu_res   = '0;
      alu_carry = 1'b0;
      case (sel_i)
         3'b000: begin
            alu_carry = add_w[width_p];
`ifdef ALU_PIPE_SAT_EN
            alu_res   = add_w[width_p] ? '1 : add_w[width_p-1:0];
`else
            alu_res   = add_w[width_p-1:0];
`endif
         end
         3'b001: begin
            // the extra top bit of the widened difference is the borrow
            alu_carry = sub_w[width_p];
`ifdef ALU_PIPE_SAT_EN
            alu_res   = sub_w[width_p] ? '0 : sub_w[width_p-1:0];
`else
            alu_res   = sub_w[width_p-1:0];
`endif
         end
         3'b010:  alu_res = a_i & b_i;
         3'b011:  alu_res = a_i | b_i;
         3'b100:  alu_res = a_i ^ b_i;
         3'b101:  alu_res = a_i << shamt;
         3'b110:  alu_res = a_i >> shamt;
         default: alu_res = {{(width_p-1){1'b0}}, (a_i < b_i)};
      endcase
      alu_zero = (alu_res == '0);
   end

   // A stage may load when some stage at or after it is empty, or the output is taken.
   always_comb begin
      stage_rdy = '0;
      all_full  = 1'b1;
      for (int i = 0; i < latency_p; i++) begin
         all_full = 1'b1;
         for (int j = i; j < latency_p; j++) begin
            all_full = all_full & valid_q[j];
         end
         stage_rdy[i] = ~all_full | yumi_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         valid_q <= '0;
         carry_q <= '0;
         zero_q  <= '0;
         for (int i = 0; i < latency_p; i++) begin
            res_q[i] <= '0;
         end
      end else begin
         if (stage_rdy[0]) begin
            valid_q[0] <= v_i;
            if (v_i) begin
               res_q[0]   <= alu_res;
               carry_q[0] <= alu_carry;
               zero_q[0]  <= alu_zero;
            end
         end
         // data registers only load real ops, so the output holds its last result while idle
         for (int i = 1; i < latency_p; i++) begin
            if (stage_rdy[i]) begin
               valid_q[i] <= valid_q[i-1];
               if (valid_q[i-1]) begin
                  res_q[i]   <= res_q[i-1];
                  carry_q[i] <= carry_q[i-1];
                  zero_q[i]  <= zero_q[i-1];
               end
            end
         end
      end
   end

   assign ready_o = stage_rdy[0];
   assign v_o     = valid_q[latency_p-1];
   assign res_o   = res_q[latency_p-1];
   assign carry_o = carry_q[latency_p-1];
   assign zero_o  = zero_q[latency_p-1];

endmodule
